// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_sw_pkg;

  // FSM state encoding, exposed directly on the state output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_e;

  // Largest legal value of a single BCD digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // One BCD digit.
  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counter (0..9) with synchronous clear and carry-out flag.
// at9 is high while the digit holds 9; the parent ANDs it with inc to build
// the increment for the next digit up.
module bcd_digit
  import bcd_sw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t q,
  output logic       at9
);

  bcd_digit_t r_q;

  // Digit register: clear wins over increment; 9 wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q   = r_q;
  assign at9 = (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: run/pause/lap FSM, cascaded BCD digits,
// sticky overflow and lap-capture display register.
// Optional feature macro: BCD_SW_LAP_EN enables the lap function. Without it
// the lap input is ignored, LAP is unreachable and disp mirrors count.
// Command inputs (start_stop, clear, lap, tick) are single-cycle strobes
// already synchronous to clk; there is no valid/ready handshake on this block.
// Command priority in one cycle: clear > start_stop > lap.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  running,
  output logic                  overflow,
  output logic [1:0]            state
);

  sw_state_e             r_state;
  sw_state_e             w_next_state;
  logic [DIGITS-1:0]     w_inc;
  logic [DIGITS-1:0]     w_at9;
  logic [4*DIGITS-1:0]   w_count;
  logic                  w_count_en;
  logic                  w_wrap;
  logic                  r_overflow;

  // Ticks count only in RUN/LAP (pre-edge state); clear discards them.
  assign w_count_en = tick && ((r_state == RUN) || (r_state == LAP)) && !clear;

  // Full-scale carry out of the top digit marks an all-9 wrap.
  assign w_wrap = w_inc[DIGITS-1] & w_at9[DIGITS-1];

  // Digit chain: digit i increments when all lower digits are 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign w_inc[g] = w_count_en;
    end else begin : g_upper
      assign w_inc[g] = w_inc[g-1] & w_at9[g-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (w_inc[g]),
      .q     (w_count[4*g +: 4]),
      .at9   (w_at9[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic with clear > start_stop > lap priority.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = IDLE;
    end else if (start_stop) begin
      case (r_state)
        IDLE:    w_next_state = RUN;
        RUN:     w_next_state = PAUSE;
        PAUSE:   w_next_state = RUN;
        LAP:     w_next_state = PAUSE;
        default: w_next_state = IDLE;
      endcase
    end
`ifdef BCD_SW_LAP_EN
    else if (lap) begin
      if (r_state == RUN) begin
        w_next_state = LAP;
      end else if (r_state == LAP) begin
        w_next_state = RUN;
      end
    end
`endif
  end

  // Sticky overflow: set on all-9 wrap, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_wrap) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef BCD_SW_LAP_EN
  logic [4*DIGITS-1:0] r_lap;

  // Lap capture: freeze the pre-edge count on the RUN->LAP transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap <= '0;
    end else if (clear) begin
      r_lap <= '0;
    end else if ((r_state == RUN) && (w_next_state == LAP)) begin
      r_lap <= w_count;
    end
  end

  assign disp = (r_state == LAP) ? r_lap : w_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign disp         = w_count;
`endif

  assign count    = w_count;
  assign overflow = r_overflow;
  assign running  = (r_state == RUN) || (r_state == LAP);
  assign state    = r_state;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (DIGITS=4). A decimal-integer
// reference model predicts every output; predictions are queued when the
// stimulus is driven and popped after the clock edge that should produce them.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         tick, start_stop, clear, lap;
  logic [W-1:0] count, disp;
  logic         running, overflow;
  logic [1:0]   state;

  bcd_stopwatch_ctrl #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .count      (count),
    .disp       (disp),
    .running    (running),
    .overflow   (overflow),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  // Packed expectation: {state, running, overflow, disp, count}
  logic [2*W+3:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  int         m_cnt;
  int         m_lap;
  logic [1:0] m_state;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2*W+3:0] model_pack();
    logic [W-1:0] d;
    logic         run;
    d   = (m_state == S_LAP) ? to_bcd(m_lap) : to_bcd(m_cnt);
    run = (m_state == S_RUN) || (m_state == S_LAP);
    return {m_state, run, m_ovf, d, to_bcd(m_cnt)};
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_lap   = 0;
    m_state = S_IDLE;
    m_ovf   = 1'b0;
  endtask

  task automatic model_apply(input logic t, input logic ss, input logic cl, input logic lp);
    logic [1:0] ns;
    logic       counted;
    counted = t && ((m_state == S_RUN) || (m_state == S_LAP)) && !cl;
    if (cl) begin
      model_reset();
    end else begin
      ns = m_state;
      if (ss) begin
        if (m_state == S_RUN || m_state == S_LAP) ns = S_PAUSE;
        else ns = S_RUN;
      end
`ifdef BCD_SW_LAP_EN
      else if (lp) begin
        if (m_state == S_RUN) ns = S_LAP;
        else if (m_state == S_LAP) ns = S_RUN;
      end
`endif
      if (m_state == S_RUN && ns == S_LAP) m_lap = m_cnt;
      if (counted) begin
        if (m_cnt == MAXV) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_state = ns;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic t, input logic ss, input logic cl, input logic lp, input bit do_chk);
    logic [2*W+3:0] e;
    @(negedge clk);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    model_apply(t, ss, cl, lp);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (do_chk) begin
      chk("count",    32'(count),    32'(e[W-1:0]));
      chk("disp",     32'(disp),     32'(e[2*W-1:W]));
      chk("overflow", 32'(overflow), 32'(e[2*W]));
      chk("running",  32'(running),  32'(e[2*W+1]));
      chk("state",    32'(state),    32'(e[2*W+3:2*W+2]));
    end
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Bound the whole run in time.
  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_count",   32'(count),    32'h0);
    chk("rst_disp",    32'(disp),     32'h0);
    chk("rst_ovf",     32'(overflow), 32'h0);
    chk("rst_running", 32'(running),  32'h0);
    chk("rst_state",   32'(state),    32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Start then 12 ticks.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(12);
    chk("run12_count",   32'(count),   32'h0012);
    chk("run12_state",   32'(state),   32'(S_RUN));
    chk("run12_running", 32'(running), 32'h1);

    // Preload to 9999, then wrap.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MAXV; i++) step(1'b1, 1'b0, 1'b0, 1'b0, (i % 1000) == 999);
    chk("preload_count", 32'(count), 32'h9999);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_count", 32'(count),    32'h0000);
    chk("wrap_ovf",   32'(overflow), 32'h1);
    ticks(3);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_ovf",   32'(overflow), 32'h0);
    chk("clr_state", 32'(state),    32'(S_IDLE));

    // Lap capture / release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(45);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ticks(10);
    chk("lap_count", 32'(count), 32'h0055);
`ifdef BCD_SW_LAP_EN
    chk("lap_disp_hold", 32'(disp),  32'h0045);
    chk("lap_state",     32'(state), 32'(S_LAP));
`else
    chk("nolap_disp",  32'(disp),  32'h0055);
    chk("nolap_state", 32'(state), 32'(S_RUN));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lap_release_disp",  32'(disp),  32'h0055);
    chk("lap_release_state", 32'(state), 32'(S_RUN));

    // clear + start_stop + tick together in RUN at 7.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("prio_count", 32'(count), 32'h0);
    chk("prio_state", 32'(state), 32'(S_IDLE));

    // start_stop + tick in RUN at 19 -> counted, then PAUSE holds.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(19);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pause_count", 32'(count), 32'h0020);
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    ticks(4);
    chk("pause_hold", 32'(count), 32'h0020);

    // Random command mix checked against the model.
    for (int i = 0; i < 400; i++) begin
      logic rt, rss, rcl, rlp;
      rt  = 1'($urandom_range(0, 1));
      rss = ($urandom_range(0, 7) == 0);
      rcl = ($urandom_range(0, 31) == 0);
      rlp = ($urandom_range(0, 5) == 0);
      step(rt, rss, rcl, rlp, 1'b1);
    end

    // Asynchronous reset mid-RUN, between clock edges.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count",   32'(count),    32'h0);
    chk("arst_disp",    32'(disp),     32'h0);
    chk("arst_ovf",     32'(overflow), 32'h0);
    chk("arst_running", 32'(running),  32'h0);
    chk("arst_state",   32'(state),    32'(S_IDLE));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(2);
    chk("post_rst_count", 32'(count), 32'h0002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, setting the number of cascaded BCD digits (legal range 1..8).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port tick, input, 1 bit: count-enable strobe, one clk wide per count event.
REQ-005 The module SHALL have port start_stop, input, 1 bit: single-cycle command pulse that toggles run/pause.
REQ-006 The module SHALL have port clear, input, 1 bit: single-cycle command pulse that zeroes the counter.
REQ-007 The module SHALL have port lap, input, 1 bit: single-cycle command pulse that freezes or releases the display.
REQ-008 The module SHALL have port count, output, 4*DIGITS bits: the live BCD value, with digit 0 in bits [3:0].
REQ-009 The module SHALL have port disp, output, 4*DIGITS bits: the displayed BCD value.
REQ-010 The module SHALL have port running, output, 1 bit: high when state is RUN or LAP.
REQ-011 The module SHALL have port overflow, output, 1 bit: sticky flag set on all-9 wrap.
REQ-012 The module SHALL have port state, output, 2 bits: FSM state encoded IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-013 FSM transitions SHALL be: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN; RUN -lap-> LAP; LAP -lap-> RUN; LAP -start_stop-> PAUSE.
REQ-014 lap SHALL be ignored in IDLE and PAUSE; any input not listed in REQ-013 SHALL leave the state unchanged.
REQ-015 Command priority within one cycle SHALL be clear > start_stop > lap; lower-priority commands in that cycle are discarded.
REQ-016 tick SHALL be counted only when the current (pre-edge) state is RUN or LAP; count updates on the same edge (1-cycle latency), and tick in a cycle where RUN/LAP is exited via start_stop still counts.
REQ-017 Counting rules: digit 0 increments on each counted tick; digit i increments only when digits 0..i-1 are all 9; any digit at 9 that increments wraps to 0; digit values SHALL never leave 0..9.
REQ-018 Wrap-around: a counted tick at all-9 SHALL produce all-0 and set overflow on the same edge.
REQ-019 overflow SHALL remain high until clear or reset.
REQ-020 clear in any state SHALL, on that edge, zero count and disp, clear overflow, force IDLE, and ignore a same-cycle tick.
REQ-021 On entering LAP, disp SHALL capture the pre-edge count (excluding any same-cycle tick) and hold it while in LAP.
REQ-022 Outside LAP, disp SHALL equal count combinationally.
REQ-023 Multi-bit inputs are not used; tick, start_stop, clear and lap SHALL be treated as already synchronous to clk.

Reset
REQ-024 While rst_n is low, the module SHALL hold count=0, disp=0, overflow=0, running=0, state=IDLE, asynchronously and independent of clk.
REQ-025 Assertion of rst_n mid-count SHALL discard all progress; the first edge after deassertion SHALL behave as in IDLE.

Configuration
REQ-026 Macro BCD_SW_LAP_EN SHALL gate the lap feature.
REQ-027 With BCD_SW_LAP_EN defined, the behaviour above SHALL apply in full.
REQ-028 Without BCD_SW_LAP_EN, the lap port SHALL remain present but be ignored, LAP SHALL be unreachable, no capture register SHALL be built, and disp SHALL equal count.

Structure
REQ-029 Package bcd_sw_pkg SHALL hold the state enum (IDLE/RUN/PAUSE/LAP), the BCD_MAX=4'd9 constant, and the digit type (4-bit logic).
REQ-030 Each digit SHALL be one instance of sub-module bcd_digit, with inputs clk, rst_n, clr, inc and outputs q[3:0], at9; the instances SHALL be chained via a generate loop over DIGITS.
REQ-031 The FSM and lap-capture register SHALL reside in the top module.

Verification
REQ-032 The bench SHALL check: reset, then start_stop, then 12 ticks -> count=0x0012, state=RUN, running=1.
REQ-033 The bench SHALL check: preload via 9999 ticks, then 1 tick -> count=0x0000 and overflow=1; then clear -> overflow=0 and state=IDLE.
REQ-034 The bench SHALL check (lap): in RUN at 0x0045, lap, then 10 ticks -> disp=0x0045 and count=0x0055; lap again -> disp=0x0055.
REQ-035 The bench SHALL check: clear, start_stop and tick asserted in the same cycle while in RUN at 0x0007 -> count=0, state=IDLE.
REQ-036 The bench SHALL check: in RUN at 0x0019, start_stop plus tick in one cycle -> count=0x0020 and state=PAUSE; further ticks leave 0x0020.
REQ-037 The bench SHALL check: rst_n pulled low mid-RUN between clk edges -> outputs zero and state=IDLE immediately, with no clk edge needed.
